// File: rtl/xmem_param_pkg.sv
// xmem bank shared constants: access sizes, bank state, lane helpers.
// Build option: XMEM_BANK_STAT_EN adds rd_cnt/wr_cnt to xmem_bank_port.
package xmem_param_pkg;

   localparam logic [1:0] LEN_BYTE = 2'd0;
   localparam logic [1:0] LEN_HALF = 2'd1;
   localparam logic [1:0] LEN_RSVD = 2'd2;
   localparam logic [1:0] LEN_WORD = 2'd3;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bank_state_t;

   function automatic logic len_ok(
      input logic [1:0] len,
      input logic [1:0] off
   );
      logic ok;
      ok = 1'b0;
      unique case (1'b1)
         (len == LEN_BYTE): ok = 1'b1;
         (len == LEN_HALF): ok = ~off[0];
         (len == LEN_WORD): ok = (off == 2'd0);
         default:           ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] lane_mask(
      input logic [1:0] len,
      input logic [1:0] off
   );
      logic [3:0] m;
      m = 4'hF;
      unique case (1'b1)
         (len == LEN_BYTE): m = 4'b0001 << off;
         (len == LEN_HALF): m = off[1] ? 4'b1100 : 4'b0011;
         default:           m = 4'hF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/xmem_bank_ram.sv
// xmem bank storage: 1RW synchronous RAM, byte write enables,
// registered read, contents never reset.
module xmem_bank_ram #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic [3:0]    i_we,
   input  logic          i_re,
   input  logic [AW-3:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   localparam int DEPTH = 2 ** (AW - 2);

   logic [3:0][7:0] r_mem [DEPTH];
   logic [31:0]     r_rdata;

   // Lane-masked write and registered read of the addressed word
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (i_we[i]) r_mem[i_addr][i] <= i_wdata[8*i +: 8];
      end
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/xmem_bank_port.sv
// xmem bank port: init-clears the RAM, then serves byte/half/word
// accesses. Build option: XMEM_BANK_STAT_EN adds rd_cnt/wr_cnt.
module xmem_bank_port
   import xmem_param_pkg::*;
#(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mux_re,
   input  logic          mux_we,
   input  logic [1:0]    mux_len,
   input  logic [AW-1:0] mux_adr,
   input  logic [DW-1:0] mux_din,
   output logic [DW-1:0] mux_dout,
   output logic          dout_vld,
   output logic          ready,
   output logic          err,
   input  logic          err_clr
`ifdef XMEM_BANK_STAT_EN
   ,
   output logic [15:0]   rd_cnt,
   output logic [15:0]   wr_cnt
`endif
);

   bank_state_t   r_state;
   logic [AW-2:0] r_init_cnt;
   logic          r_ready;
   logic          r_err;
   logic          r_vld;
   logic [1:0]    r_rd_len;
   logic [1:0]    r_rd_off;
   logic [DW-1:0] r_hold;

   logic          w_run;
   logic          w_req;
   logic          w_bad;
   logic          w_rd_ok;
   logic          w_wr_ok;
   logic          w_err_set;
   logic          w_init_wr;
   logic [3:0]    w_ram_we;
   logic [AW-3:0] w_ram_addr;
   logic [DW-1:0] w_ram_wdata;
   logic [DW-1:0] w_wdata_rep;
   logic [DW-1:0] w_ram_q;
   logic [DW-1:0] w_shift;
   logic [DW-1:0] w_aligned;

   assign w_run     = (r_state == RUN);
   assign w_req     = mux_re | mux_we;
   assign w_bad     = (mux_re & mux_we) |
                      ~len_ok(mux_len, mux_adr[1:0]);
   assign w_rd_ok   = ~rst & w_run & mux_re & ~w_bad;
   assign w_wr_ok   = ~rst & w_run & mux_we & ~w_bad;
   assign w_err_set = w_req & (~w_run | w_bad);
   assign w_init_wr = ~w_run & ~r_init_cnt[AW-2];

   // Replicate right-justified write data onto every lane
   always_comb begin
      w_wdata_rep = mux_din;
      unique case (1'b1)
         (mux_len == LEN_BYTE): w_wdata_rep = {4{mux_din[7:0]}};
         (mux_len == LEN_HALF): w_wdata_rep = {2{mux_din[15:0]}};
         default:               w_wdata_rep = mux_din;
      endcase
   end

   assign w_ram_we    = w_init_wr ? 4'hF :
                        w_wr_ok   ? lane_mask(mux_len, mux_adr[1:0]) :
                                    4'h0;
   assign w_ram_addr  = w_init_wr ? r_init_cnt[AW-3:0] : mux_adr[AW-1:2];
   assign w_ram_wdata = w_init_wr ? '0 : w_wdata_rep;

   xmem_bank_ram #(
      .AW(AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_re    (w_rd_ok),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_q)
   );

   // Bank FSM: sweep every word to zero, then run
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= INIT;
         r_init_cnt <= '0;
         r_ready    <= 1'b0;
      end else begin
         unique case (r_state)
            INIT: begin
               if (r_init_cnt[AW-2]) begin
                  r_state <= RUN;
                  r_ready <= 1'b1;
               end else begin
                  r_init_cnt <= r_init_cnt + {{(AW-2){1'b0}}, 1'b1};
               end
            end
            RUN: r_ready <= 1'b1;
            default: r_state <= INIT;
         endcase
      end
   end

   // Read-return pipeline and output hold register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld    <= 1'b0;
         r_rd_len <= LEN_BYTE;
         r_rd_off <= 2'd0;
         r_hold   <= '0;
      end else begin
         r_vld  <= w_rd_ok;
         r_hold <= mux_dout;
         if (w_rd_ok) begin
            r_rd_len <= mux_len;
            r_rd_off <= mux_adr[1:0];
         end
      end
   end

   assign w_shift = w_ram_q >> {r_rd_off, 3'b000};

   // Right-justify and zero-extend the returned lanes
   always_comb begin
      w_aligned = w_ram_q;
      unique case (1'b1)
         (r_rd_len == LEN_BYTE):
            w_aligned = {{(DW-8){1'b0}}, w_shift[7:0]};
         (r_rd_len == LEN_HALF):
            w_aligned = {{(DW-16){1'b0}}, w_shift[15:0]};
         default:
            w_aligned = w_ram_q;
      endcase
   end

   // Sticky error; a new error outranks a clear in the same cycle
   always_ff @(posedge clk) begin
      if (rst)            r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      else if (err_clr)   r_err <= 1'b0;
   end

   assign mux_dout = r_vld ? w_aligned : r_hold;
   assign dout_vld = r_vld;
   assign ready    = r_ready;
   assign err      = r_err;

`ifdef XMEM_BANK_STAT_EN
   logic [15:0] r_rd_cnt;
   logic [15:0] r_wr_cnt;

   // Saturating counts of accepted reads and writes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_rd_ok && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
         if (w_wr_ok && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      end
   end

   assign rd_cnt = r_rd_cnt;
   assign wr_cnt = r_wr_cnt;
`endif

endmodule

// File: tb/tb_xmem_bank_port.sv
// Testbench for xmem_bank_port: byte-array reference model,
// directed steps plus randomized traffic.
module tb_xmem_bank_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        mux_re;
   logic        mux_we;
   logic [1:0]  mux_len;
   logic [11:0] mux_adr;
   logic [31:0] mux_din;
   logic [31:0] mux_dout;
   logic        dout_vld;
   logic        ready;
   logic        err;
   logic        err_clr;
`ifdef XMEM_BANK_STAT_EN
   logic [15:0] rd_cnt;
   logic [15:0] wr_cnt;
`endif

   int n_chk = 0;
   int n_fail = 0;

   bit [7:0]    m_mem [4096];
   logic [31:0] m_dout;
   bit          m_err;
   bit          m_run;
   int          m_rd;
   int          m_wr;

   always #5 clk = ~clk;

   xmem_bank_port #(
      .AW(12),
      .DW(32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mux_re   (mux_re),
      .mux_we   (mux_we),
      .mux_len  (mux_len),
      .mux_adr  (mux_adr),
      .mux_din  (mux_din),
      .mux_dout (mux_dout),
      .dout_vld (dout_vld),
      .ready    (ready),
      .err      (err),
      .err_clr  (err_clr)
`ifdef XMEM_BANK_STAT_EN
      ,
      .rd_cnt   (rd_cnt),
      .wr_cnt   (wr_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [1:0] len,
                                input logic [11:0] adr);
      case (len)
         2'd0:    return 1'b1;
         2'd1:    return (adr % 2) == 0;
         2'd3:    return (adr % 4) == 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_dout = 32'h0;
      m_err  = 1'b0;
      m_run  = 1'b0;
      m_rd   = 0;
      m_wr   = 0;
   endtask

   // One request cycle, then compare all visible outputs to the model
   task automatic req(input bit re, input bit we, input logic [1:0] len,
                      input logic [11:0] adr, input logic [31:0] din,
                      input bit clr);
      bit ok;
      bit set;
      bit ev;
      int n;
      logic [31:0] v;
      mux_re = re; mux_we = we; mux_len = len;
      mux_adr = adr; mux_din = din; err_clr = clr;
      @(posedge clk);
      #1;
      mux_re = 1'b0; mux_we = 1'b0; err_clr = 1'b0;
      n   = (len == 2'd3) ? 4 : int'(len) + 1;
      ok  = m_run && !(re && we) && legal(len, adr);
      set = (re || we) && !ok;
      ev  = 1'b0;
      if (ok && we) begin
         for (int i = 0; i < n; i++) m_mem[int'(adr) + i] = din[8*i +: 8];
         if (m_wr < 65535) m_wr++;
      end
      if (ok && re) begin
         v = 32'h0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = m_mem[int'(adr) + i];
         m_dout = v;
         ev = 1'b1;
         if (m_rd < 65535) m_rd++;
      end
      m_err = set ? 1'b1 : (clr ? 1'b0 : m_err);
      check("dout_vld", {31'b0, dout_vld}, {31'b0, ev});
      check("mux_dout", mux_dout, m_dout);
      check("err", {31'b0, err}, {31'b0, m_err});
   endtask

   // Count cycles until ready, bounded; returns the count
   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (ready !== 1'b1 && cnt < 3000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      m_run = 1'b1;
   endtask

   initial begin
      int cnt;
      int r;
      logic [1:0]  len;
      logic [11:0] adr;

      rst = 1'b1; mux_re = 1'b0; mux_we = 1'b0; mux_len = 2'd0;
      mux_adr = '0; mux_din = '0; err_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_vld", {31'b0, dout_vld}, 32'd0);
      check("rst_dout", mux_dout, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      rst = 1'b0;
      wait_ready(cnt);
      check("init_cycles", cnt, 32'd1025);

      req(1, 0, 2'd3, 12'h010, 0, 0);
      check("rd_0x10", mux_dout, 32'h0);

      req(0, 1, 2'd3, 12'h020, 32'h11223344, 0);
      req(1, 0, 2'd0, 12'h021, 0, 0);
      check("rd_b_0x21", mux_dout, 32'h00000033);
      req(1, 0, 2'd1, 12'h022, 0, 0);
      check("rd_h_0x22", mux_dout, 32'h00001122);

      req(0, 1, 2'd0, 12'h023, 32'hFFFFFFAB, 0);
      req(1, 0, 2'd3, 12'h020, 0, 0);
      check("raw_0x20", mux_dout, 32'hAB223344);

      req(1, 0, 2'd1, 12'h001, 0, 0);
      check("mis_err", {31'b0, err}, 32'd1);
      req(0, 1, 2'd2, 12'h020, 32'hDEADBEEF, 1);
      check("set_wins", {31'b0, err}, 32'd1);
      req(1, 0, 2'd3, 12'h020, 0, 0);
      check("mem_kept", mux_dout, 32'hAB223344);
      req(0, 0, 2'd0, 12'h000, 0, 1);
      req(1, 1, 2'd3, 12'h040, 32'h5, 0);
      req(0, 1, 2'd3, 12'h042, 32'h5, 0);
      req(0, 0, 2'd0, 12'h000, 0, 1);

      for (int k = 0; k < 400; k++) begin
         r   = $urandom_range(0, 9);
         len = 2'($urandom_range(0, 3));
         adr = 12'($urandom_range(0, 63));
         if ($urandom_range(0, 4) != 0) begin
            if (len == 2'd1) adr[0] = 1'b0;
            if (len == 2'd3) adr[1:0] = 2'b00;
         end
         if ($urandom_range(0, 7) == 0) adr = 12'($urandom);
         req(r < 4 || r == 8, (r >= 4 && r < 9), len, adr, $urandom,
             $urandom_range(0, 15) == 0);
      end

      for (int k = 0; k < 20; k++)
         req(1, 0, 2'd3, 12'(4 * k), 0, 0);

      req(0, 1, 2'd3, 12'h020, 32'hCAFEF00D, 0);
      rst = 1'b1; mux_re = 1'b1; mux_len = 2'd3; mux_adr = 12'h020;
      @(posedge clk);
      #1;
      rst = 1'b0; mux_re = 1'b0;
      model_reset();
      check("rrd_vld", {31'b0, dout_vld}, 32'd0);
      check("rrd_ready", {31'b0, ready}, 32'd0);
      check("rrd_dout", mux_dout, 32'd0);
      req(1, 0, 2'd3, 12'h020, 0, 0);
      check("init_req_err", {31'b0, err}, 32'd1);
      check("init_ready", {31'b0, ready}, 32'd0);
      wait_ready(cnt);
      check("reinit_cycles", cnt + 1, 32'd1025);
      req(0, 0, 2'd0, 12'h000, 0, 1);
      for (int k = 0; k < 16; k++)
         req(1, 0, 2'd3, 12'(4 * k), 0, 0);
      req(1, 0, 2'd3, 12'h020, 0, 0);
      check("recleared", mux_dout, 32'h0);

`ifdef XMEM_BANK_STAT_EN
      check("wr_cnt", {16'b0, wr_cnt}, 32'(m_wr));
      check("rd_cnt", {16'b0, rd_cnt}, 32'(m_rd));
      mux_re = 1'b1; mux_len = 2'd3; mux_adr = 12'h000;
      repeat (70000) @(posedge clk);
      #1;
      mux_re = 1'b0;
      check("rd_sat", {16'b0, rd_cnt}, 32'h0000FFFF);
      check("wr_same", {16'b0, wr_cnt}, 32'(m_wr));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/xmem_bank_port.md
XMEM_BANK_PORT -- requirements
Module: xmem_bank_port

Interface
REQ-001 SHALL have parameter AW, default 12, byte-address width; word index = adr[AW-1:2], DEPTH = 2**(AW-2) words.
REQ-002 SHALL have parameter DW, default 32, data width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port mux_re, input, 1, read strobe from the request mux.
REQ-006 SHALL have port mux_we, input, 1, write strobe.
REQ-007 SHALL have port mux_len, input, 2, access size: 0=byte, 1=halfword, 3=word, 2=reserved.
REQ-008 SHALL have port mux_adr, input, AW, byte address.
REQ-009 SHALL have port mux_din, input, DW, write data, right-justified.
REQ-010 SHALL have port mux_dout, output, DW, aligned, zero-extended read data.
REQ-011 SHALL have port dout_vld, output, 1, mux_dout valid.
REQ-012 SHALL have port ready, output, 1, high once initialisation completes.
REQ-013 SHALL have port err, output, 1, sticky error flag.
REQ-014 SHALL have port err_clr, input, 1, clears err.

Function
REQ-015 SHALL implement a two-state FSM: INIT and RUN; rst forces INIT and clears the init counter.
REQ-016 In INIT, SHALL write zero to word init_cnt each cycle, incrementing init_cnt from 0 to DEPTH-1, then enter RUN on the next cycle; ready=1 only in RUN.
REQ-017 A request (mux_re or mux_we) in INIT SHALL be ignored, set err, and give dout_vld=0.
REQ-018 A write in RUN SHALL update only the addressed lanes: byte -> lane adr[1:0] = mux_din[7:0]; halfword -> lanes {adr[1],0} and {adr[1],1} = mux_din[15:0]; word -> all lanes.
REQ-019 A read in RUN SHALL give mux_dout and dout_vld=1 exactly one cycle after mux_re; mux_dout = selected byte or halfword shifted to bit 0 and zero-extended, or the full word.
REQ-020 Halfword with adr[0]=1, word with adr[1:0]!=0, mux_len=2, or mux_re&&mux_we in the same cycle SHALL perform no memory access, set err, and give dout_vld=0 (one cycle later for reads).
REQ-021 A read in the cycle after a write to the same word SHALL return the newly written data.
REQ-022 When dout_vld=0, mux_dout SHALL hold its last value.
REQ-023 Back-to-back reads SHALL be accepted every cycle, with no stall.
REQ-024 err_clr SHALL clear err; if an error condition occurs in the same cycle, err SHALL remain 1 (set wins).

Reset
REQ-025 On rst: state=INIT, init_cnt=0, ready=0, dout_vld=0, mux_dout=0, err=0, statistic counters=0.
REQ-026 rst asserted mid-read SHALL suppress the pending dout_vld; rst in RUN SHALL re-run the full INIT clearing.

Configuration
REQ-027 With XMEM_BANK_STAT_EN defined, SHALL provide outputs rd_cnt[15:0] and wr_cnt[15:0], which count accepted reads and writes in RUN and saturate at 16'hFFFF.
REQ-028 With XMEM_BANK_STAT_EN undefined, these ports and counters SHALL be absent.

Structure
REQ-029 xmem_param_pkg SHALL hold the LEN_BYTE/LEN_HALF/LEN_WORD constants and the bank state enum (INIT, RUN).
REQ-030 SHALL instantiate one sub-module, xmem_bank_ram: 1RW synchronous RAM with 4 byte-write-enables and a registered read, with no reset on its contents.

Verification
REQ-031 After rst, check ready rises after exactly DEPTH+1 cycles (1025 for AW=12), then read adr 0x10 -> 0x00000000.
REQ-032 Write word 0x11223344 @0x20, then read byte @0x21 -> 0x00000033, then halfword @0x22 -> 0x00001122, each with dout_vld one cycle after mux_re.
REQ-033 Write byte 0xAB @0x23, then immediately read word @0x20 -> 0xAB223344.
REQ-034 Halfword read @0x01 -> err=1, dout_vld=0; err_clr together with a new len=2 write -> err stays 1, and memory is unchanged.
REQ-035 Assert a request during INIT -> ignored, err=1; assert rst during a read -> no dout_vld, ready=0, and memory is re-cleared.
REQ-036 With XMEM_BANK_STAT_EN, 70000 reads -> rd_cnt=16'hFFFF and wr_cnt unchanged.
